// File: rtl/axi_outstanding_limiter.sv
// AXI4 outstanding-transaction limiter: pass-through of all channels with AR/AW gating at a limit.
// Optional response watchdog enabled by defining AXI_OUTSTANDING_WATCHDOG_EN.
module axi_outstanding_limiter #(
    parameter int unsigned LOCAL_AXI_DATA_WIDTH = 64,
    parameter int unsigned LOCAL_AXI_ADDR_WIDTH = 64,
    parameter int unsigned LOCAL_AXI_ID_WIDTH   = 4,
    parameter int unsigned MAX_READ_TXNS        = 4,
    parameter int unsigned MAX_WRITE_TXNS       = 4,
    parameter int unsigned TIMEOUT_CYCLES       = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    // Slave side: AW
    input  logic [LOCAL_AXI_ID_WIDTH-1:0]          s_axi_awid,
    input  logic [LOCAL_AXI_ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic [7:0]                             s_axi_awlen,
    input  logic [2:0]                             s_axi_awsize,
    input  logic [1:0]                             s_axi_awburst,
    input  logic                                   s_axi_awlock,
    input  logic [3:0]                             s_axi_awcache,
    input  logic [2:0]                             s_axi_awprot,
    input  logic [3:0]                             s_axi_awqos,
    input  logic [3:0]                             s_axi_awregion,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    // Slave side: W
    input  logic [LOCAL_AXI_DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [LOCAL_AXI_DATA_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                                   s_axi_wlast,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    // Slave side: B
    output logic [LOCAL_AXI_ID_WIDTH-1:0]          s_axi_bid,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    // Slave side: AR
    input  logic [LOCAL_AXI_ID_WIDTH-1:0]          s_axi_arid,
    input  logic [LOCAL_AXI_ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                             s_axi_arlen,
    input  logic [2:0]                             s_axi_arsize,
    input  logic [1:0]                             s_axi_arburst,
    input  logic                                   s_axi_arlock,
    input  logic [3:0]                             s_axi_arcache,
    input  logic [2:0]                             s_axi_arprot,
    input  logic [3:0]                             s_axi_arqos,
    input  logic [3:0]                             s_axi_arregion,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    // Slave side: R
    output logic [LOCAL_AXI_ID_WIDTH-1:0]          s_axi_rid,
    output logic [LOCAL_AXI_DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rlast,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    // Master side: AW
    output logic [LOCAL_AXI_ID_WIDTH-1:0]          m_axi_awid,
    output logic [LOCAL_AXI_ADDR_WIDTH-1:0]        m_axi_awaddr,
    output logic [7:0]                             m_axi_awlen,
    output logic [2:0]                             m_axi_awsize,
    output logic [1:0]                             m_axi_awburst,
    output logic                                   m_axi_awlock,
    output logic [3:0]                             m_axi_awcache,
    output logic [2:0]                             m_axi_awprot,
    output logic [3:0]                             m_axi_awqos,
    output logic [3:0]                             m_axi_awregion,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    // Master side: W
    output logic [LOCAL_AXI_DATA_WIDTH-1:0]        m_axi_wdata,
    output logic [LOCAL_AXI_DATA_WIDTH/8-1:0]      m_axi_wstrb,
    output logic                                   m_axi_wlast,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    // Master side: B
    input  logic [LOCAL_AXI_ID_WIDTH-1:0]          m_axi_bid,
    input  logic [1:0]                             m_axi_bresp,
    input  logic                                   m_axi_bvalid,
    output logic                                   m_axi_bready,
    // Master side: AR
    output logic [LOCAL_AXI_ID_WIDTH-1:0]          m_axi_arid,
    output logic [LOCAL_AXI_ADDR_WIDTH-1:0]        m_axi_araddr,
    output logic [7:0]                             m_axi_arlen,
    output logic [2:0]                             m_axi_arsize,
    output logic [1:0]                             m_axi_arburst,
    output logic                                   m_axi_arlock,
    output logic [3:0]                             m_axi_arcache,
    output logic [2:0]                             m_axi_arprot,
    output logic [3:0]                             m_axi_arqos,
    output logic [3:0]                             m_axi_arregion,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    // Master side: R
    input  logic [LOCAL_AXI_ID_WIDTH-1:0]          m_axi_rid,
    input  logic [LOCAL_AXI_DATA_WIDTH-1:0]        m_axi_rdata,
    input  logic [1:0]                             m_axi_rresp,
    input  logic                                   m_axi_rlast,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready,
    // Status
    input  logic                                   clear_i,
    output logic [$clog2(MAX_READ_TXNS+1)-1:0]     rd_outstanding_o,
    output logic [$clog2(MAX_WRITE_TXNS+1)-1:0]    wr_outstanding_o,
    output logic                                   idle_o,
    output logic                                   proto_err_o,
    output logic                                   timeout_o
);

    localparam int unsigned RdCntW = $clog2(MAX_READ_TXNS + 1);
    localparam int unsigned WrCntW = $clog2(MAX_WRITE_TXNS + 1);

    logic [RdCntW-1:0] rd_cnt, rd_cnt_next;
    logic [WrCntW-1:0] wr_cnt, wr_cnt_next;
    logic              proto_err, proto_err_next;
    logic              rd_full, wr_full;
    logic              rd_inc, rd_dec, rd_underflow, r_hs;
    logic              wr_inc, wr_dec, wr_underflow;
    logic              timeout_set;

    assign rd_full = (rd_cnt == RdCntW'(MAX_READ_TXNS));
    assign wr_full = (wr_cnt == WrCntW'(MAX_WRITE_TXNS));

    assign m_axi_awid     = s_axi_awid;
    assign m_axi_awaddr   = s_axi_awaddr;
    assign m_axi_awlen    = s_axi_awlen;
    assign m_axi_awsize   = s_axi_awsize;
    assign m_axi_awburst  = s_axi_awburst;
    assign m_axi_awlock   = s_axi_awlock;
    assign m_axi_awcache  = s_axi_awcache;
    assign m_axi_awprot   = s_axi_awprot;
    assign m_axi_awqos    = s_axi_awqos;
    assign m_axi_awregion = s_axi_awregion;
    assign m_axi_awvalid  = s_axi_awvalid & ~wr_full;
    assign s_axi_awready  = m_axi_awready & ~wr_full;

    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    assign m_axi_arid     = s_axi_arid;
    assign m_axi_araddr   = s_axi_araddr;
    assign m_axi_arlen    = s_axi_arlen;
    assign m_axi_arsize   = s_axi_arsize;
    assign m_axi_arburst  = s_axi_arburst;
    assign m_axi_arlock   = s_axi_arlock;
    assign m_axi_arcache  = s_axi_arcache;
    assign m_axi_arprot   = s_axi_arprot;
    assign m_axi_arqos    = s_axi_arqos;
    assign m_axi_arregion = s_axi_arregion;
    assign m_axi_arvalid  = s_axi_arvalid & ~rd_full;
    assign s_axi_arready  = m_axi_arready & ~rd_full;

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;

    assign rd_inc       = m_axi_arvalid & m_axi_arready;
    assign r_hs         = m_axi_rvalid & s_axi_rready;
    assign rd_dec       = r_hs & m_axi_rlast;
    assign rd_underflow = rd_dec & (rd_cnt == '0);
    assign wr_inc       = m_axi_awvalid & m_axi_awready;
    assign wr_dec       = m_axi_bvalid & s_axi_bready;
    assign wr_underflow = wr_dec & (wr_cnt == '0);

    // An underflowing decrement is dropped; the counters can never wrap.
    always_comb begin
        rd_cnt_next = rd_cnt;
        if (rd_inc && !rd_dec) begin
            rd_cnt_next = rd_cnt + RdCntW'(1);
        end else if (rd_dec && !rd_inc && !rd_underflow) begin
            rd_cnt_next = rd_cnt - RdCntW'(1);
        end
        wr_cnt_next = wr_cnt;
        if (wr_inc && !wr_dec) begin
            wr_cnt_next = wr_cnt + WrCntW'(1);
        end else if (wr_dec && !wr_inc && !wr_underflow) begin
            wr_cnt_next = wr_cnt - WrCntW'(1);
        end
        proto_err_next = clear_i ? 1'b0 : proto_err;
        if (rd_underflow || wr_underflow) begin
            proto_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            proto_err <= 1'b0;
        end else begin
            rd_cnt    <= rd_cnt_next;
            wr_cnt    <= wr_cnt_next;
            proto_err <= proto_err_next;
        end
    end

`ifdef AXI_OUTSTANDING_WATCHDOG_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT_CYCLES);

    logic [TmrW-1:0] rd_tmr, rd_tmr_next, wr_tmr, wr_tmr_next;
    logic            timeout, timeout_next;

    always_comb begin
        rd_tmr_next = rd_tmr;
        if (r_hs || rd_cnt == '0) begin
            rd_tmr_next = '0;
        end else if (rd_tmr != TmrMax) begin
            rd_tmr_next = rd_tmr + TmrW'(1);
        end
        wr_tmr_next = wr_tmr;
        if (wr_dec || wr_cnt == '0) begin
            wr_tmr_next = '0;
        end else if (wr_tmr != TmrMax) begin
            wr_tmr_next = wr_tmr + TmrW'(1);
        end
        timeout_set  = (rd_tmr_next == TmrMax) || (wr_tmr_next == TmrMax);
        timeout_next = clear_i ? 1'b0 : timeout;
        if (timeout_set) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_tmr  <= '0;
            wr_tmr  <= '0;
            timeout <= 1'b0;
        end else begin
            rd_tmr  <= rd_tmr_next;
            wr_tmr  <= wr_tmr_next;
            timeout <= timeout_next;
        end
    end

    assign timeout_o = timeout;
`else
    assign timeout_set = 1'b0;
    assign timeout_o   = timeout_set;
`endif

    assign rd_outstanding_o = rd_cnt;
    assign wr_outstanding_o = wr_cnt;
    assign idle_o           = (rd_cnt == '0) && (wr_cnt == '0);
    assign proto_err_o      = proto_err;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed + randomized bench for axi_outstanding_limiter against a queue-based transaction model.
// Watchdog steps are compiled in when AXI_OUTSTANDING_WATCHDOG_EN is defined.
module tb_axi_outstanding_limiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned MAX_RD = 4;
    localparam int unsigned MAX_WR = 4;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [IW-1:0] s_awid, m_awid, s_bid, m_bid, s_arid, m_arid, s_rid, m_rid;
    logic [AW-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [7:0] s_awlen, m_awlen, s_arlen, m_arlen;
    logic [2:0] s_awsize, m_awsize, s_arsize, m_arsize, s_awprot, m_awprot, s_arprot, m_arprot;
    logic [1:0] s_awburst, m_awburst, s_arburst, m_arburst, s_bresp, m_bresp, s_rresp, m_rresp;
    logic s_awlock, m_awlock, s_arlock, m_arlock;
    logic [3:0] s_awcache, m_awcache, s_arcache, m_arcache, s_awqos, m_awqos, s_arqos, m_arqos;
    logic [3:0] s_awregion, m_awregion, s_arregion, m_arregion;
    logic s_awvalid, s_awready, m_awvalid, m_awready;
    logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [DW/8-1:0] s_wstrb, m_wstrb;
    logic s_wlast, m_wlast, s_wvalid, m_wvalid, s_wready, m_wready;
    logic s_bvalid, m_bvalid, s_bready, m_bready;
    logic s_arvalid, s_arready, m_arvalid, m_arready;
    logic s_rlast, m_rlast, s_rvalid, m_rvalid, s_rready, m_rready;
    logic clear;
    logic [2:0] rd_out, wr_out;
    logic idle, proto_err, timeout;

    axi_outstanding_limiter #(
        .LOCAL_AXI_DATA_WIDTH(DW), .LOCAL_AXI_ADDR_WIDTH(AW), .LOCAL_AXI_ID_WIDTH(IW),
        .MAX_READ_TXNS(MAX_RD), .MAX_WRITE_TXNS(MAX_WR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
        .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock),
        .s_axi_awcache(s_awcache), .s_axi_awprot(s_awprot), .s_axi_awqos(s_awqos),
        .s_axi_awregion(s_awregion), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arqos(s_arqos),
        .s_axi_arregion(s_arregion), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
        .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos),
        .m_axi_awregion(m_awregion), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
        .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos),
        .m_axi_arregion(m_arregion), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .clear_i(clear), .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out),
        .idle_o(idle), .proto_err_o(proto_err), .timeout_o(timeout)
    );

    int checks = 0;
    int failures = 0;

    // Model: outstanding transactions are the IDs still waiting for their completion.
    logic [IW-1:0] rd_q[$];
    logic [IW-1:0] wr_q[$];
    logic exp_err = 1'b0;
    logic exp_to = 1'b0;
    int rd_age = 0;
    int wr_age = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rd_q.delete();
        wr_q.delete();
        exp_err = 1'b0;
        exp_to = 1'b0;
        rd_age = 0;
        wr_age = 0;
    endtask

    task automatic chk_comb();
        logic rd_room, wr_room;
        rd_room = rd_q.size() < MAX_RD;
        wr_room = wr_q.size() < MAX_WR;
        chk("m_arvalid", m_arvalid, s_arvalid && rd_room);
        chk("s_arready", s_arready, m_arready && rd_room);
        chk("m_awvalid", m_awvalid, s_awvalid && wr_room);
        chk("s_awready", s_awready, m_awready && wr_room);
        chk("m_araddr", m_araddr, s_araddr);
        chk("m_awid", m_awid, s_awid);
        chk("m_wvalid", m_wvalid, s_wvalid);
        chk("s_wready", s_wready, m_wready);
        chk("m_wdata", m_wdata, s_wdata);
        chk("s_rvalid", s_rvalid, m_rvalid);
        chk("s_rdata", s_rdata, m_rdata);
        chk("m_rready", m_rready, s_rready);
        chk("s_bvalid", s_bvalid, m_bvalid);
        chk("m_bready", m_bready, s_bready);
    endtask

    task automatic chk_reg();
        chk("rd_outstanding", rd_out, rd_q.size());
        chk("wr_outstanding", wr_out, wr_q.size());
        chk("idle", idle, rd_q.size() == 0 && wr_q.size() == 0);
        chk("proto_err", proto_err, exp_err);
        chk("timeout", timeout, exp_to);
    endtask

    // One clock cycle with the currently driven inputs; starts and ends just after a posedge.
    task automatic step();
        logic ar_hs, aw_hs, r_any, r_done, b_hs, rd_was_empty, wr_was_empty;
        #1;
        chk_comb();
        rd_was_empty = rd_q.size() == 0;
        wr_was_empty = wr_q.size() == 0;
        ar_hs  = s_arvalid && m_arready && rd_q.size() < MAX_RD;
        aw_hs  = s_awvalid && m_awready && wr_q.size() < MAX_WR;
        r_any  = m_rvalid && s_rready;
        r_done = r_any && m_rlast;
        b_hs   = m_bvalid && s_bready;
        @(posedge clk);
        #1;
        if (clear) begin
            exp_err = 1'b0;
            exp_to = 1'b0;
        end
        if (ar_hs) rd_q.push_back(s_arid);
        if (aw_hs) wr_q.push_back(s_awid);
        if (r_done) begin
            if (rd_was_empty) exp_err = 1'b1;
            if (rd_q.size() > 0) void'(rd_q.pop_front());
        end
        if (b_hs) begin
            if (wr_was_empty) exp_err = 1'b1;
            if (wr_q.size() > 0) void'(wr_q.pop_front());
        end
`ifdef AXI_OUTSTANDING_WATCHDOG_EN
        if (rd_was_empty || r_any) rd_age = 0; else if (rd_age < TO) rd_age++;
        if (wr_was_empty || b_hs) wr_age = 0; else if (wr_age < TO) wr_age++;
        if (rd_age == TO || wr_age == TO) exp_to = 1'b1;
`endif
        chk_reg();
    endtask

    task automatic quiet();
        {s_awvalid, m_awready, s_wvalid, m_wready, m_bvalid, s_bready} = '0;
        {s_arvalid, m_arready, m_rvalid, s_rready, m_rlast, clear} = '0;
    endtask

    initial begin
        {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache} = '0;
        {s_awprot, s_awqos, s_awregion, s_wdata, s_wstrb, s_wlast, m_bid, m_bresp} = '0;
        {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache} = '0;
        {s_arprot, s_arqos, s_arregion, m_rid, m_rdata, m_rresp} = '0;
        quiet();
        rst_n = 1'b0;
        model_reset();

        // Reset state; AR valid passes straight through while counts are zero
        s_arvalid = 1'b1;
        m_arready = 1'b1;
        #3;
        chk_comb();
        chk_reg();
        s_arvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill reads to the limit, then show the 5th AR is held off
        s_arvalid = 1'b1;
        m_arready = 1'b1;
        repeat (4) begin
            s_arid = IW'($urandom);
            s_araddr = {$urandom, $urandom};
            step();
        end
        chk("rd_full_count", rd_out, 3'd4);
        chk("ar_blocked", s_arready, 1'b0);
        {m_rvalid, m_rlast, s_rready} = 3'b111;
        step();
        {m_rvalid, m_rlast, s_rready} = 3'b000;
        #1;
        chk("ar_reopen", s_arready, 1'b1);
        step();
        s_arvalid = 1'b0;
        {m_rvalid, m_rlast, s_rready} = 3'b111;
        repeat (4) step();
        {m_rvalid, m_rlast, s_rready} = 3'b000;

        // Simultaneous AR accept and R-last at count 2
        s_arvalid = 1'b1;
        repeat (2) step();
        {m_rvalid, m_rlast, s_rready} = 3'b111;
        step();
        chk("simul_count", rd_out, 3'd2);
        {m_rvalid, m_rlast, s_rready} = 3'b000;
        s_arvalid = 1'b0;

        // B with no outstanding write; set beats clear in the same cycle
        {m_bvalid, s_bready} = 2'b11;
        step();
        chk("underflow_err", proto_err, 1'b1);
        chk("underflow_cnt", wr_out, 3'd0);
        clear = 1'b1;
        step();
        chk("set_wins", proto_err, 1'b1);
        {m_bvalid, s_bready} = 2'b00;
        step();
        chk("cleared", proto_err, 1'b0);
        clear = 1'b0;
        {m_bvalid, s_bready} = 2'b11;
        step();
        {m_bvalid, s_bready} = 2'b00;

        // Asynchronous reset in the middle of a cycle with three reads in flight
        s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        chk("pre_reset_cnt", rd_out, 3'd3);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_cnt", rd_out, 3'd0);
        chk_reg();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef AXI_OUTSTANDING_WATCHDOG_EN
        // One AW, no B: timeout after TO cycles
        {s_awvalid, m_awready} = 2'b11;
        step();
        {s_awvalid, m_awready} = 2'b00;
        for (int i = 1; i <= int'(TO); i++) begin
            step();
            chk("wd_expire", timeout, i >= int'(TO));
        end
        {m_bvalid, s_bready} = 2'b11;
        step();
        {m_bvalid, s_bready} = 2'b00;
        clear = 1'b1;
        step();
        clear = 1'b0;
        // B arrives at cycle 10: no timeout
        {s_awvalid, m_awready} = 2'b11;
        step();
        {s_awvalid, m_awready} = 2'b00;
        repeat (9) step();
        {m_bvalid, s_bready} = 2'b11;
        step();
        {m_bvalid, s_bready} = 2'b00;
        repeat (20) step();
        chk("wd_no_expire", timeout, 1'b0);
`endif

        // Randomized traffic; responses only while something is outstanding
        for (int n = 0; n < 600; n++) begin
            s_arvalid = 1'($urandom_range(0, 1));
            m_arready = 1'($urandom_range(0, 3) != 0);
            s_arid    = IW'($urandom);
            s_araddr  = {$urandom, $urandom};
            s_awvalid = 1'($urandom_range(0, 1));
            m_awready = 1'($urandom_range(0, 3) != 0);
            s_awid    = IW'($urandom);
            s_wvalid  = 1'($urandom_range(0, 1));
            m_wready  = 1'($urandom_range(0, 1));
            s_wdata   = {$urandom, $urandom};
            m_rvalid  = (rd_q.size() > 0) && ($urandom_range(0, 2) == 0);
            m_rlast   = 1'($urandom_range(0, 1));
            s_rready  = 1'($urandom_range(0, 3) != 0);
            m_rdata   = {$urandom, $urandom};
            m_bvalid  = (wr_q.size() > 0) && ($urandom_range(0, 2) == 0);
            s_bready  = 1'($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 15) == 0);
            step();
        end
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
